wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/arm_wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 80 ++++++++
 rtl/wb_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/arm_wb_pkg.sv
// Shared definitions for the write-back stage: register addressing and the
// layout of one buffered write-back entry.
package arm_wb_pkg;

    localparam int          REG_ADDR_W = 4;
    localparam logic [3:0]  PC_IDX     = 4'd15;
    localparam int          WB_DATA_W  = 32;

    typedef struct packed {
        logic                  wb_en;
        logic [REG_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0]  value;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back buffer kept as a shift register: slot 0 is always the oldest
// entry, so slot index doubles as age order for the forwarding search.
module wb_fifo
    import arm_wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic                  push_wb_en,
    input  logic [REG_ADDR_W-1:0] push_dest,
    input  logic [DATA_W-1:0]     push_value,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH-1:0]      ent_wb_en,
    output logic [REG_ADDR_W-1:0] ent_dest  [DEPTH],
    output logic [DATA_W-1:0]     ent_value [DEPTH]
);

    logic [DEPTH-1:0]      valid_q, valid_n;
    logic [DEPTH-1:0]      wb_en_q, wb_en_n;
    logic [REG_ADDR_W-1:0] dest_q  [DEPTH];
    logic [REG_ADDR_W-1:0] dest_n  [DEPTH];
    logic [DATA_W-1:0]     value_q [DEPTH];
    logic [DATA_W-1:0]     value_n [DEPTH];
    logic                  placed;

    always_comb begin
        valid_n = valid_q;
        wb_en_n = wb_en_q;
        dest_n  = dest_q;
        value_n = value_q;
        placed  = 1'b0;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                valid_n[i] = valid_q[i+1];
                wb_en_n[i] = wb_en_q[i+1];
                dest_n[i]  = dest_q[i+1];
                value_n[i] = value_q[i+1];
            end
            valid_n[DEPTH-1] = 1'b0;
        end
        // Valid slots are contiguous from 0, so the first free slot is the tail.
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!placed && !valid_n[i]) begin
                    valid_n[i] = 1'b1;
                    wb_en_n[i] = push_wb_en;
                    dest_n[i]  = push_dest;
                    value_n[i] = push_value;
                    placed     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_n;
        end
        wb_en_q <= wb_en_n;
        dest_q  <= dest_n;
        value_q <= value_n;
    end

    assign full      = &valid_q;
    assign empty     = !valid_q[0];
    assign ent_valid = valid_q;
    assign ent_wb_en = wb_en_q;
    assign ent_dest  = dest_q;
    assign ent_value = value_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: buffers MEM results, retires them in order to the
// register file and offers combinational forwarding from buffered entries.
module wb_stage
    import arm_wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic                  freeze,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0]     rf_value,
    input  logic [REG_ADDR_W-1:0] fwd_src1,
    input  logic [REG_ADDR_W-1:0] fwd_src2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_W-1:0]     fwd_val1,
    output logic [DATA_W-1:0]     fwd_val2,
    output logic [31:0]           retired_cnt
);

    logic                  full;
    logic                  empty;
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_wb_en;
    logic [REG_ADDR_W-1:0] ent_dest  [DEPTH];
    logic [DATA_W-1:0]     ent_value [DEPTH];
    logic                  accept;
    logic                  retire;
    logic                  head_vis;
    logic [DATA_W-1:0]     push_value;
    logic [31:0]           retired_cnt_q;

    assign in_ready   = rst && !full && !flush;
    assign accept     = in_valid && in_ready;
    assign retire     = rst && !empty && !freeze && !flush;
    assign push_value = in_mem_r_en ? in_mem_data : in_alu_res;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .pop        (retire),
        .clear      (flush),
        .push_wb_en (in_wb_en),
        .push_dest  (in_dest),
        .push_value (push_value),
        .full       (full),
        .empty      (empty),
        .ent_valid  (ent_valid),
        .ent_wb_en  (ent_wb_en),
        .ent_dest   (ent_dest),
        .ent_value  (ent_value)
    );

    // rst gating keeps the outputs quiet before the first reset edge lands.
    assign head_vis = rst && !empty;
    assign rf_we    = retire && ent_wb_en[0] && (ent_dest[0] != PC_IDX);
    assign rf_dest  = head_vis ? ent_dest[0]  : '0;
    assign rf_value = head_vis ? ent_value[0] : '0;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;
        fwd_val1 = '0;
        fwd_val2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rst && ent_valid[i] && ent_wb_en[i] && ent_dest[i] != PC_IDX) begin
                if (ent_dest[i] == fwd_src1) begin
                    fwd_hit1 = 1'b1;
                    fwd_val1 = ent_value[i];
                end
                if (ent_dest[i] == fwd_src2) begin
                    fwd_hit2 = 1'b1;
                    fwd_val2 = ent_value[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_cnt_q <= '0;
        end else if (retire) begin
            retired_cnt_q <= retired_cnt_q + 32'd1;
        end
    end

    assign retired_cnt = retired_cnt_q;

endmodule
